regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with an integrated pending-write scoreboard.

---
 rtl/priscv_rf_pkg.sv | 21 ++
 rtl/rf_scoreboard.sv | 82 ++++++++
 rtl/regfile_mp_sb.sv | 90 +++++++++
 tb/tb_regfile_mp_sb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/priscv_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : priscv_rf_pkg
//  Description: Shared constants and types for the integer register file and
//               its pending-write scoreboard.
//  Revision   : 1.0  initial release
// ============================================================================
package priscv_rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Architectural register 0 is hardwired to zero
    localparam logic [AW_DEF-1:0] REG_ZERO = '0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage : priscv_rf_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module     : rf_scoreboard
//  Description: One busy bit per architectural register. Writebacks clear
//               bits, accepted issues set them (set wins on the same reg).
//               Produces the issue handshake and a registered busy count.
//  Revision   : 1.0  initial release
// ============================================================================
module rf_scoreboard
    import priscv_rf_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NWP   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWP-1:0]    wen_i,
    input  logic [NWP*AW-1:0] waddr_i,
    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_addr_i,
    output logic              iss_ready_o,
    output logic [NREGS-1:0]  busy_o,
    output logic [AW:0]       busy_cnt_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             w_wb_hits_iss;
    logic             w_iss_is_zero;

    assign w_iss_is_zero = (iss_addr_i == AW'(REG_ZERO));

    // Issue is accepted when the destination is free, is being retired this
    // cycle (WAW resolved by the writeback), or is the zero register
    always_comb begin
        w_wb_hits_iss = 1'b0;
        for (int j = 0; j < NWP; j++) begin
            if (wen_i[j] && (waddr_i[j*AW +: AW] == iss_addr_i)) begin
                w_wb_hits_iss = 1'b1;
            end
        end
        iss_ready_o = ~busy_q[iss_addr_i] | w_wb_hits_iss | w_iss_is_zero;
    end

    // Next busy vector: clears first, then the accepted issue sets; the
    // count tracks the popcount of the vector it is registered alongside
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWP; j++) begin
            if (wen_i[j]) begin
                busy_d[waddr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid_i && iss_ready_o && !w_iss_is_zero) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    // Busy vector and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module     : regfile_mp_sb
//  Description: Multi-port integer register file (NRP read, NWP write) with
//               an integrated pending-write scoreboard. Register 0 reads 0.
//               Optional feature macro: PRISCV_RF_BYPASS_EN forwards same-
//               cycle writeback data to the read ports.
//  Revision   : 1.0  initial release
// ============================================================================
module regfile_mp_sb
    import priscv_rf_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRP   = 2,
    parameter  int NWP   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rd_busy,
    input  logic [NWP-1:0]      wen,
    input  logic [NWP*AW-1:0]   waddr,
    input  logic [NWP*XLEN-1:0] wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] w_busy;
    logic [NRP-1:0]   w_fwd_hit;

    // Storage: ports applied in index order so the highest port wins on a
    // shared address; register 0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWP; j++) begin
                if (wen[j] && (waddr[j*AW +: AW] != AW'(REG_ZERO))) begin
                    regs_q[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxes, optional writeback forwarding, and RAW hazard flags
    always_comb begin
        rdata     = '0;
        rd_busy   = '0;
        w_fwd_hit = '0;
        for (int i = 0; i < NRP; i++) begin
            if (raddr[i*AW +: AW] != AW'(REG_ZERO)) begin
                rdata[i*XLEN +: XLEN] = regs_q[raddr[i*AW +: AW]];
`ifdef PRISCV_RF_BYPASS_EN
                for (int j = 0; j < NWP; j++) begin
                    if (wen[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
                        rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
                        w_fwd_hit[i]          = 1'b1;
                    end
                end
`endif
            end
            rd_busy[i] = w_busy[raddr[i*AW +: AW]] & ~w_fwd_hit[i];
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWP   (NWP)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .wen_i       (wen),
        .waddr_i     (waddr),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .iss_ready_o (iss_ready),
        .busy_o      (w_busy),
        .busy_cnt_o  (busy_cnt)
    );

endmodule : regfile_mp_sb
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module     : tb_regfile_mp_sb
//  Description: Directed table-driven bench for regfile_mp_sb (default
//               parameters, two read and two write ports).
//  Revision   : 1.0  initial release
// ============================================================================
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rd_busy;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        erdy;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [12];

    regfile_mp_sb dut (
        .clk       (clk),
        .reset     (reset),
        .raddr     (raddr),
        .rdata     (rdata),
        .rd_busy   (rd_busy),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after a rising edge, check mid-cycle,
    // then advance to just after the next rising edge
    task automatic cyc(input vec_t v, input string name);
        reset     = v.rst;
        wen       = v.wen;
        waddr     = {v.wa1, v.wa0};
        wdata     = {v.wd1, v.wd0};
        iss_valid = v.iv;
        iss_addr  = v.ia;
        raddr     = {v.ra1, v.ra0};
        #4;
        checks++;
        if (rdata[31:0] !== v.e0) begin
            errors++;
            $display("FAIL %s rdata0 got %h exp %h", name, rdata[31:0], v.e0);
        end
        checks++;
        if (rdata[63:32] !== v.e1) begin
            errors++;
            $display("FAIL %s rdata1 got %h exp %h", name, rdata[63:32], v.e1);
        end
        checks++;
        if (rd_busy !== v.eb) begin
            errors++;
            $display("FAIL %s rd_busy got %b exp %b", name, rd_busy, v.eb);
        end
        checks++;
        if (iss_ready !== v.erdy) begin
            errors++;
            $display("FAIL %s iss_ready got %b exp %b", name, iss_ready, v.erdy);
        end
        checks++;
        if (busy_cnt !== v.ecnt) begin
            errors++;
            $display("FAIL %s busy_cnt got %0d exp %0d", name, busy_cnt, v.ecnt);
        end
        @(posedge clk);
        #1;
    endtask

    // Read every register in pairs: all data and busy bits must be zero
    task automatic check_all_zero(input string name);
        vec_t v;
        for (int r = 0; r < 16; r++) begin
            v = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0,
                  5'(2*r), 5'(2*r+1), 32'h0, 32'h0, 2'b00, 1'b1, 6'd0};
            cyc(v, name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        //          rst wen   wa0  wd0           wa1  wd1     iv   ia    ra0  ra1   e0            e1            eb     rdy  cnt
        vecs[0]  = '{1'b1, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd1, 5'd31, 32'h0,        32'h0,        2'b00, 1'b1, 6'd0};
        vecs[1]  = '{1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd6, 5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 6'd0};
        vecs[2]  = '{1'b0, 2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 1'b1, 6'd0};
        vecs[3]  = '{1'b0, 2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 1'b1, 6'd0};
        vecs[4]  = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd7, 5'd5,  32'h22,       32'hDEADBEEF, 2'b00, 1'b1, 6'd0};
        vecs[5]  = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd7,  32'h0,        32'h22,       2'b01, 1'b0, 6'd1};
        vecs[6]  = '{1'b0, 2'b01, 5'd3, 32'h33,       5'd0, 32'h0,  1'b1, 5'd3, 5'd7, 5'd5,  32'h22,       32'hDEADBEEF, 2'b00, 1'b1, 6'd1};
        vecs[7]  = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9, 5'd3, 5'd0,  32'h33,       32'h0,        2'b01, 1'b1, 6'd1};
        vecs[8]  = '{1'b0, 2'b01, 5'd3, 32'h44,       5'd0, 32'h0,  1'b0, 5'd0, 5'd1, 5'd9,  32'h0,        32'h0,        2'b10, 1'b1, 6'd2};
        vecs[9]  = '{1'b0, 2'b01, 5'd4, 32'h55,       5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd9,  32'h44,       32'h0,        2'b10, 1'b1, 6'd1};
        vecs[10] = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd0, 5'd4, 5'd3,  32'h55,       32'h44,       2'b00, 1'b1, 6'd1};
        vecs[11] = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd9, 5'd0, 5'd9,  32'h0,        32'h0,        2'b10, 1'b0, 6'd1};

        reset     = 1'b1;
        wen       = '0;
        waddr     = '0;
        wdata     = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        raddr     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_read_all");

        for (int k = 0; k < 12; k++) begin
            cyc(vecs[k], $sformatf("vec%0d", k));
        end

        // Writeback r9 while reading it in the same cycle
`ifdef PRISCV_RF_BYPASS_EN
        v = '{1'b0, 2'b01, 5'd9, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
              32'hA5, 32'h0, 2'b00, 1'b1, 6'd1};
`else
        v = '{1'b0, 2'b01, 5'd9, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
              32'h0, 32'h0, 2'b01, 1'b1, 6'd1};
`endif
        cyc(v, "wb_same_cycle_read");
        v = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd9, 5'd13,
              32'hA5, 32'h0, 2'b00, 1'b1, 6'd0};
        cyc(v, "wb_next_cycle_read");

        // Reset overrides concurrent writes and issue
        v = '{1'b1, 2'b11, 5'd10, 32'h1, 5'd11, 32'h2, 1'b1, 5'd14, 5'd13, 5'd7,
              32'h0, 32'h22, 2'b01, 1'b1, 6'd1};
        cyc(v, "reset_cycle");
        v = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd13, 5'd10, 5'd11,
              32'h0, 32'h0, 2'b00, 1'b1, 6'd0};
        cyc(v, "after_reset");
        check_all_zero("after_reset_all");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_mp_sb
`default_nettype wire
